req_onehot_rr: RTL
==================

REQ_ONEHOT_RR -- requirements
Module: req_onehot_rr

Interface
REQ-001 Parameter: RR, default 1, 1 = round-robin selection, 0 = fixed priority (bit 0 highest).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  per-channel request; a bit high in any cycle marks that channel pending.
REQ-005 Port: ready  input  1  downstream encoder stage accepts the current one-hot word.
REQ-006 Port: onehot  output  4  one-hot channel word driving the 4x2 encoder's I input; 4'b0000 when not valid.
REQ-007 Port: valid  output  1  onehot holds exactly one set bit and is offered.
REQ-008 Port: ovf_clr  input  1  clears all sticky overflow flags.
REQ-009 Port: ovf  output  4  per-channel sticky flag: request arrived while that channel was already pending.
REQ-010 Port: pend  output  4  current pending vector, for status.

Function
REQ-011 pend[i] sets on the clock edge after any cycle with req[i]=1; it clears only on acceptance of channel i.
REQ-012 Acceptance is valid=1 and ready=1 in the same cycle.
REQ-013 FSM states: IDLE, OFFER; all outputs registered.
REQ-014 IDLE: if pend!=0, select a channel, load onehot with its bit, set valid, go to OFFER; else stay, valid=0, onehot=0.
REQ-015 Selection ignores requests arriving in the same cycle; it uses the registered pend.
REQ-016 RR=1: search starts at (last+1) mod 4 and wraps 3->0; last is the index of the most recently accepted channel.
REQ-017 RR=0: lowest set index of pend wins.
REQ-018 OFFER: onehot and valid are held constant until acceptance; ready low stalls indefinitely.
REQ-019 On acceptance: clear pend[i], set last=i, valid=0, onehot=0, return to IDLE; peak rate is one word per 2 cycles.
REQ-020 If req[i]=1 in the acceptance cycle of channel i, pend[i] stays set (new request wins over clear); no overflow is flagged.
REQ-021 If req[i]=1 while pend[i]=1 outside REQ-020, set ovf[i]; the request is merged, not queued.
REQ-022 ovf_clr=1 clears ovf on the next edge; a simultaneous new overflow event wins and leaves its bit set.
REQ-023 While valid=1, onehot has exactly one bit set; while valid=0, onehot=4'b0000 so the encoder reports V=0.

Reset
REQ-024 rst_n low asynchronously forces: state IDLE, valid=0, onehot=0, pend=0, ovf=0, last=3 (so channel 0 is first after reset).
REQ-025 Reset during OFFER discards the offered word and all pending requests; no acceptance is recorded.
REQ-026 Reset deassertion takes effect at the first clock edge with rst_n high; requests in that cycle are captured.

Structure
REQ-027 State encodings (IDLE, OFFER), channel count 4 and reset value of last belong in the shared encoder package.
REQ-028 One sub-module, rr_pick4: combinational pick of the one-hot winner from pend, last and RR; all registers stay in the top level.

Verification
REQ-029 Reset, then req=4'b1010 for 1 cycle, ready=1 -> onehot=4'b0010 valid, then 4'b1000; encoder sees 0010 then 1000; pend ends 0.
REQ-030 RR=1, req=4'b1111 held 1 cycle, ready=1 -> accepted order 0001,0010,0100,1000, one per 2 cycles; RR=0 with req 1111 re-driven each grant -> always 0001, ovf[0]=1.
REQ-031 Stall: offer 4'b0100 with ready=0 for 10 cycles, req[0] pulses meanwhile -> onehot stays 0100; after ready=1 the next offer is 0001.
REQ-032 req[2] high in the acceptance cycle of channel 2 -> pend[2] stays 1, ovf[2]=0, channel 2 re-offered later.
REQ-033 req[1] pulsed twice before acceptance -> ovf=4'b0010; ovf_clr pulse -> ovf=0; ovf_clr with a coincident overflow on channel 3 -> ovf=4'b1000.
REQ-034 rst_n low mid-OFFER (asynchronous, between edges) -> valid=0, onehot=0, pend=0 immediately; first post-reset grant is channel 0 when req=1111.

Source files
------------

// File: rtl/req_onehot_rr_pkg.sv
// Shared definitions for the request-to-one-hot arbiter that feeds the
// 4x2 priority encoder.
//   N_CH     : number of request channels
//   LAST_RST : reset value of the last-accepted index (3, so channel 0 leads)
//   state_t  : arbiter FSM encoding
//   oh_idx   : binary index of a one-hot word
package req_onehot_rr_pkg;

   localparam int N_CH = 4;
   localparam logic [1:0] LAST_RST = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_t;

   function automatic logic [1:0] oh_idx(input logic [N_CH-1:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < N_CH; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/req_onehot_rr_pick4.sv
// Combinational winner pick for the arbiter.
//   RR   : 1 = round-robin starting after last, 0 = fixed priority (bit 0 first)
//   pend : pending channel vector
//   last : index of the most recently accepted channel
//   pick : one-hot winner, 0 when pend is empty
module rr_pick4
   import req_onehot_rr_pkg::*;
#(
   parameter bit RR = 1'b1
) (
   input  logic [N_CH-1:0] pend,
   input  logic [1:0]      last,
   output logic [N_CH-1:0] pick
);

   logic       found;
   logic [1:0] cand;

   // 2-bit candidate arithmetic wraps 3->0 on its own.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      cand  = 2'd0;
      for (int j = 0; j < N_CH; j++) begin
         cand = RR ? (last + 2'(j + 1)) : 2'(j);
         if (!found && pend[cand]) begin
            found = 1'b1;
            pick  = 4'b0001 << cand;
         end
      end
   end

endmodule

// File: rtl/req_onehot_rr.sv
// Request arbiter producing a one-hot word for the downstream 4x2 encoder.
//   clk     : clock
//   rst_n   : async active-low reset
//   req     : per-channel request pulses (marks channel pending)
//   ready   : encoder accepts the current word
//   onehot  : offered one-hot word, 0 when not valid
//   valid   : onehot is being offered
//   ovf_clr : clears sticky overflow flags
//   ovf     : sticky per-channel overflow (request merged into pending)
//   pend    : pending vector
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | nothing offered; picks a winner if pend != 0
// OFFER | onehot/valid held until ready
module req_onehot_rr
   import req_onehot_rr_pkg::*;
#(
   parameter bit RR = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] req,
   input  logic            ready,
   output logic [N_CH-1:0] onehot,
   output logic            valid,
   input  logic            ovf_clr,
   output logic [N_CH-1:0] ovf,
   output logic [N_CH-1:0] pend
);

   state_t          state;
   logic [1:0]      last;
   logic [N_CH-1:0] pick;
   logic [N_CH-1:0] acc_mask;
   logic [N_CH-1:0] ovf_ev;

   rr_pick4 #(.RR(RR)) u_pick (
      .pend (pend),
      .last (last),
      .pick (pick)
   );

   assign acc_mask = (valid && ready) ? onehot : '0;
   // A request on the channel being accepted re-arms it instead of overflowing.
   assign ovf_ev   = req & pend & ~acc_mask;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         onehot <= '0;
         valid  <= 1'b0;
         pend   <= '0;
         ovf    <= '0;
         last   <= LAST_RST;
      end else begin
         pend <= (pend & ~acc_mask) | req;
         ovf  <= (ovf_clr ? '0 : ovf) | ovf_ev;
         case (state)
            IDLE: begin
               if (|pend) begin
                  onehot <= pick;
                  valid  <= 1'b1;
                  state  <= OFFER;
               end
            end
            OFFER: begin
               if (ready) begin
                  last   <= oh_idx(onehot);
                  onehot <= '0;
                  valid  <= 1'b0;
                  state  <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
